// File: rtl/tour_pkg.sv
// Shared constants and types for the knight's-tour command sequencer.
package tour_pkg;

  localparam logic [3:0] MOVE_OP    = 4'h4;
  localparam logic [3:0] FANFARE_OP = 4'h5;

  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  typedef logic [7:0] move_t;

  localparam move_t MV_B0 = 8'h01;  // (+1,+2)
  localparam move_t MV_B1 = 8'h02;  // (-1,+2)
  localparam move_t MV_B2 = 8'h04;  // (-2,+1)
  localparam move_t MV_B3 = 8'h08;  // (-2,-1)
  localparam move_t MV_B4 = 8'h10;  // (-1,-2)
  localparam move_t MV_B5 = 8'h20;  // (+1,-2)
  localparam move_t MV_B6 = 8'h40;  // (+2,-1)
  localparam move_t MV_B7 = 8'h80;  // (+2,+1)

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERT,
    ST_HOLDV,
    ST_HORZ,
    ST_HOLDH
  } state_t;

  // Builds {opcode, heading, squares}; squares are at most 2 so zero-extend.
  function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [1:0] sq);
    return {op, hdg, 2'b00, sq};
  endfunction

endpackage

// File: rtl/move_decode.sv
// Combinational decode of a one-hot knight move into its two cmd_proc legs.
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic       dx_pos;
  logic       dy_pos;
  logic [1:0] dx_mag;
  logic [1:0] dy_mag;

  // Map the one-hot move to direction signs and magnitudes, then build both legs.
  always_comb begin
    dx_pos = 1'b1;
    dy_pos = 1'b1;
    dx_mag = 2'd1;
    dy_mag = 2'd2;
    case (move)
      MV_B0: begin dx_pos = 1'b1; dx_mag = 2'd1; dy_pos = 1'b1; dy_mag = 2'd2; end
      MV_B1: begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b1; dy_mag = 2'd2; end
      MV_B2: begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
      MV_B3: begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
      MV_B4: begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
      MV_B5: begin dx_pos = 1'b1; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
      MV_B6: begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
      MV_B7: begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
      default: ;  // non-one-hot moves never come from TourLogic
    endcase
    vert_cmd = make_cmd(MOVE_OP, dy_pos ? HDG_NORTH : HDG_SOUTH, dy_mag);
    horz_cmd = make_cmd(FANFARE_OP, dx_pos ? HDG_EAST : HDG_WEST, dx_mag);
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays a solved knight's tour as cmd_proc commands; passes UART commands
// through while idle and selects the response byte for the remote.
module tour_cmd_sequencer
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t      state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  move_decode u_move_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  assign mv_indx   = mv_indx_q;
  assign last_move = (mv_indx_q == LAST_IDX);

  // State and move-index registers; reset aborts any tour in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Next-state, index advance and output mux; clr_cmd_rdy only matters in
  // the presenting states and send_resp only in the hold states, so a
  // simultaneous pair naturally acts on clr_cmd_rdy alone.
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    cmd       = cmd_UART;
    cmd_rdy   = cmd_rdy_UART;
    resp      = 8'h5A;
    case (state_q)
      ST_IDLE: begin
        resp = 8'hA5;
        if (start_tour) begin
          state_d   = ST_VERT;
          mv_indx_d = 5'd0;
        end
      end
      ST_VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = ST_HOLDV;
      end
      ST_HOLDV: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b0;
        if (send_resp) state_d = ST_HORZ;
      end
      ST_HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = ST_HOLDH;
      end
      ST_HOLDH: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b0;
        if (last_move) resp = 8'hA5;
        if (send_resp) begin
          if (last_move) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
